// File: rtl/pkt_an_pkg.sv
// rtl/pkt_an_pkg.sv - shared cell message fields and arbiter state encoding
package pkt_an_pkg;

  localparam int SOC_BIT = 3;
  localparam int EOC_BIT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_st_e;

  typedef struct packed {
    logic soc;
    logic eoc;
  } cell_flag_t;

  // Caller passes the msg[SOC_BIT:EOC_BIT] slice of one cell message.
  function automatic cell_flag_t msg_flags(input logic [SOC_BIT:EOC_BIT] f);
    return cell_flag_t'(f);
  endfunction

endpackage

// File: rtl/pkt_an_rr_pick.sv
// rtl/pkt_an_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module pkt_an_rr_pick #(
  parameter int NUM_PORT = 2,
  localparam int PW = $clog2(NUM_PORT)
) (
  input  logic [NUM_PORT-1:0] req,
  input  logic [PW-1:0]       ptr,
  output logic [NUM_PORT-1:0] gnt,
  output logic [PW-1:0]       idx,
  output logic                any
);

  logic [PW:0]   sum;
  logic [PW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    j   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_PORT)) sum = sum - (PW+1)'(NUM_PORT);
      j = sum[PW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/pkt_an_cell_arb.sv
// rtl/pkt_an_cell_arb.sv - packet-atomic round-robin arbiter onto the analyzer cell input
module pkt_an_cell_arb
  import pkt_an_pkg::*;
#(
  parameter int NUM_PORT = 2,
  parameter int DWID     = 256,
  parameter int FCMWID   = 50,
  parameter int CELL_SZ  = 8,
  parameter int DBG_WID  = 32,
  localparam int PW = $clog2(NUM_PORT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORT-1:0]        cfg_port_en,
  input  logic [NUM_PORT-1:0]        in_cell_vld,
  output logic [NUM_PORT-1:0]        in_cell_rdy,
  input  logic [NUM_PORT*DWID-1:0]   in_cell_dat,
  input  logic [NUM_PORT*FCMWID-1:0] in_cell_msg,
  output logic                       fst_cell_vld,
  input  logic                       fst_cell_rdy,
  output logic [DWID-1:0]            fst_cell_dat,
  output logic [FCMWID-1:0]          fst_cell_msg,
  output logic [PW-1:0]              fst_cell_port,
  output logic [DBG_WID-1:0]         dbg_sig
);

  localparam int CW = $clog2(CELL_SZ + 1);

  arb_st_e             st_q, st_d;
  logic [PW-1:0]       lock_q, lock_d, rr_q, rr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_PORT-1:0] drop_q, drop_d;
  logic [15:0]         err_q, err_d, pkt_q, pkt_d;

  logic                load_en;
  logic [NUM_PORT-1:0] soc, eoc, req, locked, discard, stray, grant_rdy;
  logic [NUM_PORT-1:0] pick_gnt;
  logic [PW-1:0]       pick_idx, src;
  logic                pick_any, acc, sel_soc, sel_eoc, len_hit, pkt_end;
  logic [DWID-1:0]     sel_dat;
  logic [FCMWID-1:0]   sel_msg, out_msg;

  assign load_en = !fst_cell_vld || fst_cell_rdy;

  always_comb begin
    soc = '0;
    eoc = '0;
    for (int i = 0; i < NUM_PORT; i++)
      {soc[i], eoc[i]} = msg_flags(in_cell_msg[i*FCMWID+EOC_BIT +: 2]);
  end

  always_comb begin
    locked = '0;
    if (st_q == ST_LOCK) locked[lock_q] = 1'b1;
  end

  // Non-SOC heads on any port other than the locked one are thrown away without
  // touching the output register; only enabled or drop-flagged ports qualify.
  assign req     = in_cell_vld & soc & cfg_port_en;
  assign discard = in_cell_vld & ~soc & ~locked & (drop_q | cfg_port_en);
  assign stray   = discard & ~drop_q;

  pkt_an_rr_pick #(.NUM_PORT(NUM_PORT)) u_pick (
    .req (req),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    acc       = 1'b0;
    src       = pick_idx;
    grant_rdy = '0;
    if (st_q == ST_IDLE) begin
      acc = pick_any && load_en;
      if (load_en) grant_rdy = pick_gnt;
    end else begin
      src               = lock_q;
      acc               = in_cell_vld[lock_q] && load_en;
      grant_rdy[lock_q] = load_en;
    end
  end

  assign in_cell_rdy = rst ? (discard | grant_rdy) : '0;

  always_comb begin
    sel_dat = in_cell_dat[int'(src)*DWID +: DWID];
    sel_msg = in_cell_msg[int'(src)*FCMWID +: FCMWID];
    sel_soc = soc[src];
    sel_eoc = eoc[src];
    len_hit = (st_q == ST_LOCK) && acc && !sel_eoc && (cnt_q == CW'(CELL_SZ - 1));
    pkt_end = acc && (sel_eoc || len_hit);
    out_msg = sel_msg;
    if (len_hit) out_msg[EOC_BIT] = 1'b1;
  end

  always_comb begin
    st_d   = st_q;
    lock_d = lock_q;
    rr_d   = rr_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    err_d  = err_q;
    pkt_d  = pkt_q;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (discard[i] && eoc[i]) drop_d[i] = 1'b0;
      err_d = err_d + 16'(stray[i]);
    end
    case (st_q)
      ST_IDLE: begin
        if (acc) begin
          drop_d[src] = 1'b0;
          if (!sel_eoc) begin
            st_d   = ST_LOCK;
            lock_d = src;
            cnt_d  = CW'(1);
          end
        end
      end
      ST_LOCK: begin
        if (acc) begin
          cnt_d = cnt_q + CW'(1);
          if (sel_soc) err_d = err_d + 16'd1;
          if (pkt_end) st_d = ST_IDLE;
          if (len_hit) begin
            err_d          = err_d + 16'd1;
            drop_d[lock_q] = 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (pkt_end) begin
      pkt_d = pkt_q + 16'd1;
      rr_d  = (src == PW'(NUM_PORT - 1)) ? '0 : src + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q          <= ST_IDLE;
      lock_q        <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      drop_q        <= '0;
      err_q         <= '0;
      pkt_q         <= '0;
      fst_cell_vld  <= 1'b0;
      fst_cell_dat  <= '0;
      fst_cell_msg  <= '0;
      fst_cell_port <= '0;
    end else begin
      st_q   <= st_d;
      lock_q <= lock_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      err_q  <= err_d;
      pkt_q  <= pkt_d;
      if (load_en) begin
        fst_cell_vld <= acc;
        if (acc) begin
          fst_cell_dat  <= sel_dat;
          fst_cell_msg  <= out_msg;
          fst_cell_port <= src;
        end
      end
    end
  end

  assign dbg_sig = DBG_WID'({err_q, pkt_q});

endmodule

// File: tb/tb_pkt_an_cell_arb.sv
// tb/tb_pkt_an_cell_arb.sv - table-driven and sequence checks for pkt_an_cell_arb
module tb_pkt_an_cell_arb;

  logic         clk;
  logic         rst;
  logic [1:0]   cfg_port_en;
  logic [1:0]   in_cell_vld;
  logic [1:0]   in_cell_rdy;
  logic [511:0] in_cell_dat;
  logic [99:0]  in_cell_msg;
  logic         fst_cell_vld;
  logic         fst_cell_rdy;
  logic [255:0] fst_cell_dat;
  logic [49:0]  fst_cell_msg;
  logic         fst_cell_port;
  logic [31:0]  dbg_sig;

  int total = 0;
  int bad   = 0;

  pkt_an_cell_arb dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_port_en   (cfg_port_en),
    .in_cell_vld   (in_cell_vld),
    .in_cell_rdy   (in_cell_rdy),
    .in_cell_dat   (in_cell_dat),
    .in_cell_msg   (in_cell_msg),
    .fst_cell_vld  (fst_cell_vld),
    .fst_cell_rdy  (fst_cell_rdy),
    .fst_cell_dat  (fst_cell_dat),
    .fst_cell_msg  (fst_cell_msg),
    .fst_cell_port (fst_cell_port),
    .dbg_sig       (dbg_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  vld;
    logic [3:0]  m0;
    logic [3:0]  m1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        frdy;
    logic [1:0]  x_rdy;
    logic        x_vld;
    logic        x_port;
    logic [7:0]  x_dat;
    logic [3:0]  x_msg;
    logic [15:0] x_err;
    logic [15:0] x_pkt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [1:0] en, input logic [1:0] vld, input logic [3:0] m0,
                     input logic [3:0] m1, input logic [7:0] d0, input logic [7:0] d1,
                     input logic frdy);
    @(negedge clk);
    cfg_port_en  = en;
    in_cell_vld  = vld;
    in_cell_msg  = {46'd0, m1, 46'd0, m0};
    in_cell_dat  = {248'd0, d1, 248'd0, d0};
    fst_cell_rdy = frdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic xv, input logic xp, input logic [7:0] xd,
                         input logic [3:0] xm, input logic [15:0] xe, input logic [15:0] xk);
    chk({nm, "_vld"}, 32'(fst_cell_vld), 32'(xv));
    if (xv) begin
      chk({nm, "_port"}, 32'(fst_cell_port), 32'(xp));
      chk({nm, "_dat"}, fst_cell_dat[31:0], 32'(xd));
      chk({nm, "_msg"}, fst_cell_msg[31:0], 32'(xm));
    end
    chk({nm, "_err"}, 32'(dbg_sig[31:16]), 32'(xe));
    chk({nm, "_pkt"}, 32'(dbg_sig[15:0]), 32'(xk));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // en, vld, m0, m1, d0, d1, frdy | x_rdy, x_vld, x_port, x_dat, x_msg, x_err, x_pkt
    tbl[0]  = '{2'b11, 2'b11, 4'h8, 4'h8, 8'h01, 8'h11, 1'b1, 2'b01, 1'b1, 1'b0, 8'h01, 4'h8, 16'd0, 16'd0};
    tbl[1]  = '{2'b11, 2'b11, 4'h4, 4'h8, 8'h02, 8'h11, 1'b1, 2'b01, 1'b1, 1'b0, 8'h02, 4'h4, 16'd0, 16'd1};
    tbl[2]  = '{2'b11, 2'b10, 4'h0, 4'h8, 8'h00, 8'h11, 1'b1, 2'b10, 1'b1, 1'b1, 8'h11, 4'h8, 16'd0, 16'd1};
    tbl[3]  = '{2'b11, 2'b10, 4'h0, 4'h4, 8'h00, 8'h12, 1'b1, 2'b10, 1'b1, 1'b1, 8'h12, 4'h4, 16'd0, 16'd2};
    tbl[4]  = '{2'b11, 2'b01, 4'h8, 4'h0, 8'h21, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'h21, 4'h8, 16'd0, 16'd2};
    tbl[5]  = '{2'b11, 2'b01, 4'h0, 4'h0, 8'h22, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'h22, 4'h0, 16'd0, 16'd2};
    tbl[6]  = '{2'b11, 2'b01, 4'h4, 4'h0, 8'h23, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'h23, 4'h4, 16'd0, 16'd3};
    tbl[7]  = '{2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 16'd0, 16'd3};
    tbl[8]  = '{2'b11, 2'b11, 4'h0, 4'h8, 8'h31, 8'h41, 1'b1, 2'b11, 1'b1, 1'b1, 8'h41, 4'h8, 16'd1, 16'd3};
    tbl[9]  = '{2'b11, 2'b10, 4'h0, 4'h4, 8'h00, 8'h42, 1'b1, 2'b10, 1'b1, 1'b1, 8'h42, 4'h4, 16'd1, 16'd4};
    tbl[10] = '{2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 16'd1, 16'd4};
    tbl[11] = '{2'b10, 2'b01, 4'h8, 4'h0, 8'h51, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 16'd1, 16'd4};
    tbl[12] = '{2'b10, 2'b01, 4'h0, 4'h0, 8'h52, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 16'd1, 16'd4};
    tbl[13] = '{2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 16'd1, 16'd4};
    tbl[14] = '{2'b11, 2'b01, 4'h8, 4'h0, 8'h61, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'h61, 4'h8, 16'd1, 16'd4};
    tbl[15] = '{2'b11, 2'b01, 4'h8, 4'h0, 8'h62, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'h62, 4'h8, 16'd2, 16'd4};
    tbl[16] = '{2'b11, 2'b01, 4'h4, 4'h0, 8'h63, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'h63, 4'h4, 16'd2, 16'd5};
    tbl[17] = '{2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 16'd2, 16'd5};

    rst          = 1'b0;
    cfg_port_en  = 2'b11;
    in_cell_vld  = 2'b00;
    in_cell_dat  = '0;
    in_cell_msg  = '0;
    fst_cell_rdy = 1'b1;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_vld", 32'(fst_cell_vld), 32'd0);
    chk("rst_dbg", dbg_sig, 32'd0);
    chk("rst_rdy", 32'(in_cell_rdy), 32'd0);
    chk("rst_dat", fst_cell_dat[31:0], 32'd0);
    chk("rst_msg", fst_cell_msg[31:0], 32'd0);
    chk("rst_port", 32'(fst_cell_port), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drv(tbl[i].en, tbl[i].vld, tbl[i].m0, tbl[i].m1, tbl[i].d0, tbl[i].d1, tbl[i].frdy);
      chk($sformatf("r%0d_rdy", i), 32'(in_cell_rdy), 32'(tbl[i].x_rdy));
      tick();
      chk_out($sformatf("r%0d", i), tbl[i].x_vld, tbl[i].x_port, tbl[i].x_dat, tbl[i].x_msg,
              tbl[i].x_err, tbl[i].x_pkt);
    end

    // backpressure mid-packet: output held, nothing accepted
    drv(2'b11, 2'b01, 4'h8, 4'h0, 8'h71, 8'h00, 1'b1);
    tick();
    chk_out("bp_c1", 1'b1, 1'b0, 8'h71, 4'h8, 16'd2, 16'd5);
    drv(2'b11, 2'b01, 4'h0, 4'h0, 8'h72, 8'h00, 1'b1);
    tick();
    chk_out("bp_c2", 1'b1, 1'b0, 8'h72, 4'h0, 16'd2, 16'd5);
    for (int k = 0; k < 5; k++) begin
      drv(2'b11, 2'b01, 4'h0, 4'h0, 8'h73, 8'h00, 1'b0);
      chk($sformatf("bp_hold%0d_rdy", k), 32'(in_cell_rdy), 32'd0);
      tick();
      chk_out($sformatf("bp_hold%0d", k), 1'b1, 1'b0, 8'h72, 4'h0, 16'd2, 16'd5);
    end
    drv(2'b11, 2'b01, 4'h0, 4'h0, 8'h73, 8'h00, 1'b1);
    chk("bp_rel_rdy", 32'(in_cell_rdy), 32'd1);
    tick();
    chk_out("bp_c3", 1'b1, 1'b0, 8'h73, 4'h0, 16'd2, 16'd5);
    drv(2'b11, 2'b01, 4'h4, 4'h0, 8'h74, 8'h00, 1'b1);
    tick();
    chk_out("bp_c4", 1'b1, 1'b0, 8'h74, 4'h4, 16'd2, 16'd6);
    drv(2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);
    tick();
    chk_out("bp_end", 1'b0, 1'b0, 8'h00, 4'h0, 16'd2, 16'd6);

    // over-length packet on port1: 8th cell gets forced EOC, rest dropped
    for (int k = 1; k <= 10; k++) begin
      drv(2'b11, 2'b10, 4'h0, (k == 1) ? 4'h8 : 4'h0, 8'h00, 8'(8'h80 + k), 1'b1);
      chk($sformatf("len%0d_rdy", k), 32'(in_cell_rdy), 32'd2);
      tick();
      if (k < 8)
        chk_out($sformatf("len%0d", k), 1'b1, 1'b1, 8'(8'h80 + k), (k == 1) ? 4'h8 : 4'h0,
                16'd2, 16'd6);
      else if (k == 8)
        chk_out("len8", 1'b1, 1'b1, 8'h88, 4'h4, 16'd3, 16'd7);
      else
        chk_out($sformatf("len%0d", k), 1'b0, 1'b0, 8'h00, 4'h0, 16'd3, 16'd7);
    end
    drv(2'b11, 2'b10, 4'h0, 4'h8, 8'h00, 8'h91, 1'b1);
    chk("len_soc_rdy", 32'(in_cell_rdy), 32'd2);
    tick();
    chk_out("len_soc", 1'b1, 1'b1, 8'h91, 4'h8, 16'd3, 16'd7);
    drv(2'b11, 2'b10, 4'h0, 4'h4, 8'h00, 8'h92, 1'b1);
    tick();
    chk_out("len_eoc", 1'b1, 1'b1, 8'h92, 4'h4, 16'd3, 16'd8);

    // asynchronous reset during the second cell of a packet
    drv(2'b11, 2'b01, 4'h8, 4'h0, 8'hA1, 8'h00, 1'b1);
    tick();
    chk_out("ar_c1", 1'b1, 1'b0, 8'hA1, 4'h8, 16'd3, 16'd8);
    drv(2'b11, 2'b01, 4'h0, 4'h0, 8'hA2, 8'h00, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_vld", 32'(fst_cell_vld), 32'd0);
    chk("ar_dbg", dbg_sig, 32'd0);
    chk("ar_rdy", 32'(in_cell_rdy), 32'd0);
    chk("ar_dat", fst_cell_dat[31:0], 32'd0);
    tick();
    drv(2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);
    rst = 1'b1;
    drv(2'b11, 2'b01, 4'h8, 4'h0, 8'hB1, 8'h00, 1'b1);
    chk("ar_new_rdy", 32'(in_cell_rdy), 32'd1);
    tick();
    chk_out("ar_new1", 1'b1, 1'b0, 8'hB1, 4'h8, 16'd0, 16'd0);
    drv(2'b11, 2'b01, 4'h4, 4'h0, 8'hB2, 8'h00, 1'b1);
    tick();
    chk_out("ar_new2", 1'b1, 1'b0, 8'hB2, 4'h4, 16'd0, 16'd1);
    drv(2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);
    tick();
    chk_out("ar_idle", 1'b0, 1'b0, 8'h00, 4'h0, 16'd0, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
